apb_master_bridge: RTL and testbench

//  Upstream APB requester: converts a valid/ready command stream (read/write, addr, data) into
//  APB SETUP/ACCESS transfers toward a single APB slave, waits on p_ready, and returns read data
//  and error status on a valid/ready response channel. One outstanding transfer at a time.

---
 rtl/apb_pkg.sv | 19 +
 rtl/apb_master_bridge.sv | 150 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB master bridge: FSM state encoding and the command payload.
package apb_pkg;

   localparam int unsigned APB_A_WIDTH = 8;
   localparam int unsigned APB_D_WIDTH = 8;

   typedef enum logic [1:0] {
      APB_IDLE   = 2'd0,
      APB_SETUP  = 2'd1,
      APB_ACCESS = 2'd2
   } apb_state_e;

   typedef struct packed {
      logic                   write;
      logic [APB_A_WIDTH-1:0] addr;
      logic [APB_D_WIDTH-1:0] wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to single-slave APB requester, one transfer in flight.
// Optional ACCESS-phase watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned A_WIDTH     = APB_A_WIDTH,
   parameter int unsigned D_WIDTH     = APB_D_WIDTH,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic               p_clk,
   input  logic               p_rstn,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_write,
   input  logic [A_WIDTH-1:0] req_addr,
   input  logic [D_WIDTH-1:0] req_wdata,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [D_WIDTH-1:0] rsp_rdata,
   output logic               rsp_err,
   output logic               rsp_timeout,
   output logic               p_sel,
   output logic               p_enable,
   output logic               p_write,
   output logic [A_WIDTH-1:0] p_addr,
   output logic [D_WIDTH-1:0] wr_data,
   input  logic [D_WIDTH-1:0] rd_data,
   input  logic               p_ready,
   input  logic               p_slverr
);

   apb_state_e         r_state;
   apb_state_e         w_state_nxt;
   logic               w_accept;
   logic               w_done;
   logic               w_abort;
   logic               w_to_hit;
   logic               r_sel;
   logic               r_enable;
   logic               r_write;
   logic [A_WIDTH-1:0] r_addr;
   logic [D_WIDTH-1:0] r_wdata;
   logic               r_rsp_valid;
   logic [D_WIDTH-1:0] r_rsp_rdata;
   logic               r_rsp_err;

   // A held response blocks new commands so only one transfer is ever outstanding.
   assign req_ready = p_rstn && (r_state == APB_IDLE) && !r_rsp_valid;
   assign w_accept  = req_valid && req_ready;

   always_ff @(posedge p_clk or negedge p_rstn) begin : state_reg
      if (!p_rstn) r_state <= APB_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin : next_state
      w_state_nxt = r_state;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         APB_IDLE:   if (w_accept) w_state_nxt = APB_SETUP;
         APB_SETUP:  w_state_nxt = APB_ACCESS;
         APB_ACCESS: begin
            if (p_ready) begin
               w_done      = 1'b1;
               w_state_nxt = APB_IDLE;
            end else if (w_to_hit) begin
               w_abort     = 1'b1;
               w_state_nxt = APB_IDLE;
            end
         end
         default:    w_state_nxt = APB_IDLE;
      endcase
   end

   // APB pins are registered from the next state so SETUP/ACCESS line up with the FSM.
   always_ff @(posedge p_clk or negedge p_rstn) begin : apb_regs
      if (!p_rstn) begin
         r_sel       <= 1'b0;
         r_enable    <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_sel    <= (w_state_nxt != APB_IDLE);
         r_enable <= (w_state_nxt == APB_ACCESS);
         if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_done) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_write ? '0 : rd_data;
            r_rsp_err   <= p_slverr;
         end else if (w_abort) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
         end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] r_to_cnt;
   logic             r_rsp_timeout;

   // Abort on the edge where the count of stalled ACCESS cycles would reach TIMEOUT_CYC.
   assign w_to_hit = !p_ready && (r_to_cnt >= CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge p_clk or negedge p_rstn) begin : timeout_regs
      if (!p_rstn) begin
         r_to_cnt      <= '0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (r_state != APB_ACCESS)
            r_to_cnt <= '0;
         else if (!p_ready && (r_to_cnt != CNT_W'(TIMEOUT_CYC)))
            r_to_cnt <= r_to_cnt + CNT_W'(1);
         if (w_done)       r_rsp_timeout <= 1'b0;
         else if (w_abort) r_rsp_timeout <= 1'b1;
      end
   end

   assign rsp_timeout = r_rsp_timeout;
`else
   logic [31:0] w_unused_timeout;

   assign w_unused_timeout = 32'(TIMEOUT_CYC);
   assign w_to_hit         = 1'b0;
   assign rsp_timeout      = 1'b0;
`endif

   assign p_sel     = r_sel;
   assign p_enable  = r_enable;
   assign p_write   = r_write;
   assign p_addr    = r_addr;
   assign wr_data   = r_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: transaction-level model plus a small APB slave.
// Timeout-specific expectations follow APB_TIMEOUT_EN as seen by the bench compile.
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam int unsigned AW = APB_A_WIDTH;
   localparam int unsigned DW = APB_D_WIDTH;
   localparam int          TO = 16;
   localparam int          STUCK = 1000;

   logic          p_clk = 1'b0;
   logic          p_rstn;
   logic          req_valid, req_ready, req_write;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          p_sel, p_enable, p_write;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] wr_data, rd_data;
   logic          p_ready, p_slverr;

   apb_master_bridge #(.A_WIDTH(AW), .D_WIDTH(DW), .TIMEOUT_CYC(TO)) dut (
      .p_clk(p_clk), .p_rstn(p_rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_addr(p_addr),
      .wr_data(wr_data), .rd_data(rd_data), .p_ready(p_ready), .p_slverr(p_slverr)
   );

   always #5 p_clk = ~p_clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Pending commands plus per-command slave behaviour (wait cycles, slverr).
   apb_req_t      q_cmd[$];
   int            q_wait[$];
   bit            q_err[$];

   // Transaction model: a transfer is k cycles old; SETUP at k=1, ACCESS k=2..m_last.
   bit            m_busy = 0, m_pend = 0, m_abort = 0, m_err = 0;
   int            m_k = 0, m_last = 0, m_wait = 0;
   apb_req_t      m_cmd = '0;
   logic [DW-1:0] m_rdata = '0;
   bit            m_rerr = 0, m_rto = 0;

   logic [DW-1:0] mem [256];
   int            s_acc = 0;
   int            cyc = 0;
   bit            rsp_hold = 0;
   int            acc_obs = 0;
   int            last_accept = -1, last_rsp_rise = -1;
   logic [DW-1:0] last_rsp_rdata = '0;
   logic          last_rsp_err = 0, last_rsp_to = 0;
   bit            prev_rsp_valid = 0;
   int            accept_log[$];

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int w, input bit e);
      apb_req_t c;
      c.write = wr; c.addr = a; c.wdata = d;
      q_cmd.push_back(c); q_wait.push_back(w); q_err.push_back(e);
   endtask

   // One clock cycle: compare, drive slave and requester, advance the model at the edge.
   task automatic step();
      bit            in_acc, acc_now, cons, wr_now;
      logic [AW-1:0] wr_a;
      logic [DW-1:0] wr_d, rd_exp;
      check("p_sel", p_sel, m_busy);
      check("p_enable", p_enable, m_busy && (m_k >= 2));
      if (m_busy) begin
         check("p_addr", p_addr, m_cmd.addr);
         check("p_write", p_write, m_cmd.write);
         check("wr_data", wr_data, m_cmd.wdata);
      end
      check("rsp_valid", rsp_valid, m_pend);
      if (m_pend) begin
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("rsp_err", rsp_err, m_rerr);
         check("rsp_timeout", rsp_timeout, m_rto);
      end
      if (p_sel && p_enable) acc_obs++;
      if (rsp_valid && !prev_rsp_valid) begin
         last_rsp_rise  = cyc;
         last_rsp_rdata = rsp_rdata;
         last_rsp_err   = rsp_err;
         last_rsp_to    = rsp_timeout;
      end
      prev_rsp_valid = rsp_valid;

      in_acc = (p_sel === 1'b1) && (p_enable === 1'b1);
      if (in_acc) begin
         s_acc++;
         p_ready  = (s_acc > m_wait);
         p_slverr = p_ready ? m_err : 1'b1;
      end else begin
         s_acc    = 0;
         p_ready  = 1'b1;
         p_slverr = 1'b1;
      end
      rd_data = (in_acc && p_ready) ? mem[p_addr] : 8'hA5;
      wr_now  = in_acc && p_ready && p_write;
      wr_a    = p_addr;
      wr_d    = wr_data;
      rd_exp  = mem[m_cmd.addr];

      if (q_cmd.size() != 0) begin
         req_valid = 1'b1;
         req_write = q_cmd[0].write;
         req_addr  = q_cmd[0].addr;
         req_wdata = q_cmd[0].wdata;
      end else begin
         req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      end
      rsp_ready = !rsp_hold;
      #1;
      check("req_ready", req_ready, p_rstn && !m_busy && !m_pend);
      acc_now = p_rstn && !m_busy && !m_pend && req_valid;
      cons    = m_pend && rsp_ready;

      @(posedge p_clk);
      if (p_rstn) begin
         if (wr_now) mem[wr_a] = wr_d;
         if (cons) m_pend = 0;
         if (m_busy) begin
            if (m_k == m_last) begin
               m_busy  = 0;
               m_pend  = 1;
               m_rdata = (m_abort || m_cmd.write) ? '0 : rd_exp;
               m_rerr  = m_abort ? 1'b1 : m_err;
               m_rto   = m_abort;
            end else begin
               m_k++;
            end
         end else if (acc_now) begin
            m_cmd  = q_cmd.pop_front();
            m_wait = q_wait.pop_front();
            m_err  = q_err.pop_front();
            m_busy = 1; m_k = 1; acc_obs = 0;
            last_accept = cyc;
            accept_log.push_back(cyc);
`ifdef APB_TIMEOUT_EN
            m_abort = (m_wait >= TO);
            m_last  = m_abort ? 1 + TO : 2 + m_wait;
`else
            m_abort = 0;
            m_last  = 2 + m_wait;
`endif
         end
      end
      cyc++;
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((m_busy || m_pend || q_cmd.size() != 0) && n < budget) begin
         step();
         n++;
      end
      check("drain_done", m_busy || m_pend || (q_cmd.size() != 0), 1'b0);
   endtask

   // Asynchronous reset asserted mid-cycle; the model drops everything in flight.
   task automatic mid_reset();
      #2 p_rstn = 1'b0;
      #1;
      check("rst_p_sel", p_sel, 1'b0);
      check("rst_p_enable", p_enable, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 1'b0);
      m_busy = 0; m_pend = 0; s_acc = 0;
      q_cmd.delete(); q_wait.delete(); q_err.delete();
      run(2);
      p_rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rec;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
      p_rstn = 1'b1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0;
      rsp_ready = 0; rd_data = '0; p_ready = 0; p_slverr = 0;
      #2 p_rstn = 1'b0;
      #1;
      check("reset_p_sel", p_sel, 1'b0);
      check("reset_p_enable", p_enable, 1'b0);
      check("reset_p_write", p_write, 1'b0);
      check("reset_p_addr", p_addr, 8'h00);
      check("reset_wr_data", wr_data, 8'h00);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_rsp_rdata", rsp_rdata, 8'h00);
      check("reset_rsp_err", rsp_err, 1'b0);
      check("reset_rsp_timeout", rsp_timeout, 1'b0);
      check("reset_req_ready", req_ready, 1'b0);
      @(posedge p_clk); #1;
      run(2);
      p_rstn = 1'b1;
      run(2);

      // Write 0x3C to 0x05, zero-wait slave: response three cycles after accept.
      issue(1'b1, 8'h05, 8'h3C, 0, 1'b0);
      drain(40);
      check("t1_latency", last_rsp_rise - last_accept, 3);
      check("t1_access_cycles", acc_obs, 1);
      check("t1_rdata", last_rsp_rdata, 8'h00);
      check("t1_err", last_rsp_err, 1'b0);
      check("t1_mem5", mem[5], 8'h3C);

      // Read back with four wait states.
      issue(1'b0, 8'h05, 8'h00, 4, 1'b0);
      drain(40);
      check("t2_access_cycles", acc_obs, 5);
      check("t2_rdata", last_rsp_rdata, 8'h3C);
      check("t2_err", last_rsp_err, 1'b0);
      check("t2_latency", last_rsp_rise - last_accept, 7);

      // Read with slave error, response held back; a second read waits behind it.
      rsp_hold = 1;
      issue(1'b0, 8'h05, 8'h00, 0, 1'b1);
      issue(1'b0, 8'h07, 8'h00, 0, 1'b0);
      for (int i = 0; i < 20 && !m_pend; i++) step();
      run(5);
      check("t3_valid_held", rsp_valid, 1'b1);
      check("t3_err", rsp_err, 1'b1);
      check("t3_rdata", rsp_rdata, 8'h3C);
      check("t3_req_ready", req_ready, 1'b0);
      rsp_hold = 0;
      rec = cyc;
      run(2);
      check("t3_accept_after_consume", last_accept, rec + 1);
      drain(40);
      check("t3b_rdata", last_rsp_rdata, 8'hC4);
      check("t3b_err", last_rsp_err, 1'b0);

      // Write with slave error still completes and updates the slave.
      issue(1'b1, 8'h30, 8'h55, 1, 1'b1);
      drain(40);
      check("wr_err_flag", last_rsp_err, 1'b1);
      check("wr_err_rdata", last_rsp_rdata, 8'h00);
      check("wr_err_mem", mem[8'h30], 8'h55);

      // Reset during ACCESS drops the transfer without a response.
      issue(1'b1, 8'h10, 8'hEE, 3, 1'b0);
      for (int i = 0; i < 10 && !(m_busy && m_k == 3); i++) step();
      check("t4_in_access", p_enable, 1'b1);
      mid_reset();
      run(4);
      check("t4_no_rsp", rsp_valid, 1'b0);
      check("t4_mem_untouched", mem[8'h10], 8'hD3);

      // Slave that never becomes ready.
      issue(1'b0, 8'h20, 8'h00, STUCK, 1'b0);
`ifdef APB_TIMEOUT_EN
      drain(60);
      check("t5_access_cycles", acc_obs, TO);
      check("t5_err", last_rsp_err, 1'b1);
      check("t5_timeout", last_rsp_to, 1'b1);
      check("t5_rdata", last_rsp_rdata, 8'h00);
      issue(1'b0, 8'h21, 8'h00, TO - 1, 1'b0);
      drain(60);
      check("t5_edge_access_cycles", acc_obs, TO);
      check("t5_edge_timeout", last_rsp_to, 1'b0);
      check("t5_edge_rdata", last_rsp_rdata, 8'hE2);
`else
      run(100);
      check("t5_pending_sel", p_sel, 1'b1);
      check("t5_pending_enable", p_enable, 1'b1);
      check("t5_no_rsp", rsp_valid, 1'b0);
      check("t5_timeout_low", rsp_timeout, 1'b0);
      mid_reset();
      run(2);
`endif

      // Eight back-to-back writes with rsp_ready high: one accept every four cycles.
      accept_log.delete();
      for (int i = 0; i < 8; i++) issue(1'b1, 8'(8'h40 + i), 8'(i * 17 + 3), 0, 1'b0);
      drain(100);
      check("t6_count", accept_log.size(), 8);
      for (int i = 1; i < accept_log.size(); i++)
         check("t6_spacing", accept_log[i] - accept_log[i-1], 4);
      check("t6_mem_first", mem[8'h40], 8'h03);
      check("t6_mem_last", mem[8'h47], 8'h7A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
